// File: rtl/eth_hdr_parser.sv
// Ethernet header parser: captures dst/src MAC and ethertype from a gap-delimited
// byte burst, then streams the payload with the trailing FCS held back and dropped.
module eth_hdr_parser #(
  parameter int P_GAP       = 4,
  parameter int P_STRIP_FCS = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  data_in,
  input  logic        data_in_vld,
  output logic [47:0] dst_mac,
  output logic [47:0] src_mac,
  output logic [15:0] eth_type,
  output logic        hdr_vld,
  output logic [7:0]  pay_data,
  output logic        pay_vld,
  output logic        pay_last,
  output logic        frame_done,
  output logic [10:0] pay_len,
  output logic        runt,
  output logic [1:0]  fsm_state
);

  localparam int          H         = 4 * P_STRIP_FCS + 1;
  localparam logic [3:0]  GAP_LAST  = 4'(P_GAP - 1);
  localparam logic [4:0]  MIN_LEN   = 5'(14 + 4 * P_STRIP_FCS);
  localparam logic [2:0]  PIPE_FULL = 3'(H);
  localparam logic [10:0] LEN_MAX   = 11'h7ff;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PAY  = 2'd2,
    S_END  = 2'd3
  } state_t;

  state_t        state;
  logic [3:0]    gap_cnt;
  logic [4:0]    byte_cnt;
  logic [103:0]  hdr_sr;
  logic [7:0]    pipe [H];
  logic [2:0]    pipe_cnt;
  logic [10:0]   len_cnt;

  assign fsm_state = state;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_IDLE;
      gap_cnt    <= '0;
      byte_cnt   <= '0;
      hdr_sr     <= '0;
      pipe_cnt   <= '0;
      len_cnt    <= '0;
      for (int i = 0; i < H; i++) pipe[i] <= '0;
      dst_mac    <= '0;
      src_mac    <= '0;
      eth_type   <= '0;
      hdr_vld    <= 1'b0;
      pay_data   <= '0;
      pay_vld    <= 1'b0;
      pay_last   <= 1'b0;
      frame_done <= 1'b0;
      pay_len    <= '0;
      runt       <= 1'b0;
    end else begin
      hdr_vld    <= 1'b0;
      pay_vld    <= 1'b0;
      pay_last   <= 1'b0;
      frame_done <= 1'b0;
      runt       <= 1'b0;
      pay_len    <= '0;

      case (state)
        S_IDLE: begin
          if (data_in_vld) begin
            hdr_sr   <= {hdr_sr[95:0], data_in};
            byte_cnt <= 5'd1;
            gap_cnt  <= '0;
            state    <= S_HDR;
          end
        end

        S_HDR: begin
          if (data_in_vld) begin
            gap_cnt  <= '0;
            hdr_sr   <= {hdr_sr[95:0], data_in};
            byte_cnt <= byte_cnt + 5'd1;
            // hdr_sr holds bytes 0..12 here; byte 13 is on data_in
            if (byte_cnt == 5'd13) begin
              dst_mac  <= hdr_sr[103:56];
              src_mac  <= hdr_sr[55:8];
              eth_type <= {hdr_sr[7:0], data_in};
              hdr_vld  <= 1'b1;
              state    <= S_PAY;
            end
          end else if (gap_cnt == GAP_LAST) begin
            state <= S_END;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end

        S_PAY: begin
          if (data_in_vld) begin
            gap_cnt <= '0;
            if (byte_cnt != 5'd31) byte_cnt <= byte_cnt + 5'd1;
            pipe[0] <= data_in;
            for (int i = 1; i < H; i++) pipe[i] <= pipe[i-1];
            if (pipe_cnt == PIPE_FULL) begin
              pay_data <= pipe[H-1];
              pay_vld  <= 1'b1;
              if (len_cnt != LEN_MAX) len_cnt <= len_cnt + 11'd1;
            end else begin
              pipe_cnt <= pipe_cnt + 3'd1;
            end
          end else if (gap_cnt == GAP_LAST) begin
            state <= S_END;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end

        S_END: begin
          // A full pipe implies at least MIN_LEN bytes, so runt never coincides with a last beat
          if (byte_cnt < MIN_LEN) begin
            runt <= 1'b1;
          end else begin
            frame_done <= 1'b1;
            if (pipe_cnt == PIPE_FULL) begin
              pay_data <= pipe[H-1];
              pay_vld  <= 1'b1;
              pay_last <= 1'b1;
              pay_len  <= (len_cnt == LEN_MAX) ? LEN_MAX : len_cnt + 11'd1;
            end else begin
              pay_len <= len_cnt;
            end
          end
          pipe_cnt <= '0;
          len_cnt  <= '0;
          gap_cnt  <= '0;
          if (data_in_vld) begin
            hdr_sr   <= {hdr_sr[95:0], data_in};
            byte_cnt <= 5'd1;
            state    <= S_HDR;
          end else begin
            byte_cnt <= '0;
            state    <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
